uart_rx_fifo: RTL and testbench

Receive-side buffer between the `buart` receiver and the FemtoRV32 memory bus. It drains each received byte from the UART as soon as the UART flags it valid, so back-to-back characters at 115200 baud are not lost while the CPU is busy. Bytes are stored in a small circular FIFO. The block exposes a memory-mapped data register and a status/control register, plus a level-triggered interrupt that feeds the CPU interrupt OR.

---
 rtl/uart_rx_fifo.sv | 104 ++++++++++
 tb/tb_uart_rx_fifo.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO between the buart receiver and the CPU bus.
// Exposes a data register, a status/control register and a level interrupt.
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        uart_valid,
  input  logic [7:0]  uart_data,
  output logic        uart_rd,
  input  logic        sys_select_data,
  input  logic        sys_select_status,
  input  logic        sys_rd,
  input  logic [3:0]  sys_we,
  input  logic [31:0] sys_wdata,
  output logic [31:0] sys_rdata,
  output logic        irq
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE   = 1;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = 1;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rp;
  logic [DEPTH_LOG2-1:0] wp;
  logic [DEPTH_LOG2:0]   count;
  logic [7:0]            threshold;
  logic                  overflow;

  logic empty, full;
  logic push_req, rd_data, rd_status;
  logic ctl_wr, flush, clr_ovf, thr_wr;
  logic pop, store, ovf_event;
  logic [31:0] head_word, status_word;

  // NOTE: every always_comb output is assigned on every path, so no latch can be inferred.
  always_comb begin
    empty     = (count == '0);
    full      = (count == DEPTH_CNT);
    push_req  = uart_valid & ~uart_rd;
    rd_data   = sys_rd & sys_select_data;
    rd_status = sys_rd & sys_select_status & ~sys_select_data;
    ctl_wr    = sys_select_status & sys_we[0];
    flush     = ctl_wr & sys_wdata[0];
    clr_ovf   = ctl_wr & sys_wdata[1];
    thr_wr    = sys_select_status & sys_we[1];
    pop       = rd_data & ~empty & ~flush;
    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    store     = push_req & (~full | pop) & ~flush & ~reset;
    ovf_event = push_req & full & ~pop & ~flush;
  end

  always_comb begin
    head_word   = {23'b0, 1'b1, mem[rp]};
    status_word = {16'b0, threshold, 2'b00, overflow, full, 4'(count)};
  end

  assign irq = (threshold != 8'd0) && (8'(count) >= threshold);

  // NOTE: the storage array has no reset; pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (store) mem[wp] <= uart_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rp        <= '0;
      wp        <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      threshold <= 8'd1;
      uart_rd   <= 1'b0;
      sys_rdata <= '0;
    end else begin
      uart_rd <= push_req;

      if (flush) begin
        rp    <= '0;
        wp    <= '0;
        count <= '0;
      end else begin
        if (pop)   rp <= rp + PTR_ONE;
        if (store) wp <= wp + PTR_ONE;
        if (store && !pop)      count <= count + CNT_ONE;
        else if (pop && !store) count <= count - CNT_ONE;
      end

      // A fresh overflow outranks a clear issued in the same cycle.
      if (ovf_event)    overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;

      if (thr_wr) threshold <= sys_wdata[15:8];

      if (rd_data)        sys_rdata <= empty ? '0 : head_word;
      else if (rd_status) sys_rdata <= status_word;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{sys_wdata[31:16], sys_wdata[7:2], sys_we[3:2]};

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        uart_valid;
  logic [7:0]  uart_data;
  logic        uart_rd;
  logic        sys_select_data;
  logic        sys_select_status;
  logic        sys_rd;
  logic [3:0]  sys_we;
  logic [31:0] sys_wdata;
  logic [31:0] sys_rdata;
  logic        irq;

  always #5 clk = ~clk;

  uart_rx_fifo #(.DEPTH_LOG2(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .uart_valid        (uart_valid),
    .uart_data         (uart_data),
    .uart_rd           (uart_rd),
    .sys_select_data   (sys_select_data),
    .sys_select_status (sys_select_status),
    .sys_rd            (sys_rd),
    .sys_we            (sys_we),
    .sys_wdata         (sys_wdata),
    .sys_rdata         (sys_rdata),
    .irq               (irq)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Reference model: the FIFO is a queue; status/read words are built from its size.
  logic [7:0]  q[$];
  logic        m_ovf;
  logic [7:0]  m_thr;
  logic        m_rd;
  logic [31:0] m_rdata;
  bit          cmp_en = 1'b0;

  function automatic logic m_irq();
    return (m_thr != 8'd0) && (q.size() >= int'(m_thr));
  endfunction

  always @(posedge clk) begin : model
    bit push_req, rd_d, rd_s, wr, flush, clr, full, ovf_ev;
    int n;
    if (reset) begin
      q.delete();
      m_ovf   = 1'b0;
      m_thr   = 8'd1;
      m_rd    = 1'b0;
      m_rdata = '0;
    end else begin
      push_req = uart_valid && !m_rd;
      rd_d     = sys_rd && sys_select_data;
      rd_s     = sys_rd && sys_select_status && !rd_d;
      wr       = sys_select_status;
      flush    = wr && sys_we[0] && sys_wdata[0];
      clr      = wr && sys_we[0] && sys_wdata[1];
      n        = q.size();
      full     = (n == DEPTH);
      if (rd_d)      m_rdata = (n == 0) ? 32'd0 : {23'd0, 1'b1, q[0]};
      else if (rd_s) m_rdata = {16'd0, m_thr, 2'b00, m_ovf, full, 4'(n % 16)};
      ovf_ev = 1'b0;
      if (flush) q.delete();
      else begin
        if (rd_d && n > 0) void'(q.pop_front());
        if (push_req) begin
          if (q.size() < DEPTH) q.push_back(uart_data);
          else ovf_ev = 1'b1;
        end
      end
      if (ovf_ev)   m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      if (wr && sys_we[1]) m_thr = sys_wdata[15:8];
      m_rd = push_req;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("uart_rd", 32'(uart_rd), 32'(m_rd));
      check("irq", 32'(irq), 32'(m_irq()));
      check("sys_rdata", sys_rdata, m_rdata);
    end
  end

  // buart emulation: holds valid until the cycle after it sees the acknowledge.
  logic [7:0] tx_q[$];
  bit         acked;

  task automatic uart_emul();
    if (acked) begin
      uart_valid = 1'b0;
      acked      = 1'b0;
    end else if (uart_valid && uart_rd) begin
      acked = 1'b1;
    end
    if (!uart_valid && tx_q.size() > 0) begin
      uart_data  = tx_q.pop_front();
      uart_valid = 1'b1;
    end
  endtask

  task automatic step();
    @(negedge clk);
    uart_emul();
  endtask

  task automatic wait_idle(output int pulses);
    bit done;
    done   = 1'b0;
    pulses = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      step();
      if (uart_rd) pulses++;
      if (tx_q.size() == 0 && !uart_valid && !acked && !uart_rd) done = 1'b1;
    end
    if (!done) check("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int p;
    wait_idle(p);
  endtask

  task automatic read_data(output logic [31:0] v);
    sys_select_data = 1'b1;
    sys_rd          = 1'b1;
    step();
    sys_select_data = 1'b0;
    sys_rd          = 1'b0;
    v = sys_rdata;
  endtask

  task automatic read_status(output logic [31:0] v);
    sys_select_status = 1'b1;
    sys_rd            = 1'b1;
    step();
    sys_select_status = 1'b0;
    sys_rd            = 1'b0;
    v = sys_rdata;
  endtask

  task automatic write_status(input logic [3:0] we, input logic [31:0] d);
    sys_select_status = 1'b1;
    sys_we            = we;
    sys_wdata         = d;
    step();
    sys_select_status = 1'b0;
    sys_we            = '0;
    sys_wdata         = '0;
  endtask

  initial begin
    logic [31:0] v;
    logic [7:0]  exp_b[$];
    int          pulses;
    bit          found;
    logic [31:0] d;
    int          rd_pct;

    reset = 1'b1;
    uart_valid = 1'b0; uart_data = '0;
    sys_select_data = 1'b0; sys_select_status = 1'b0;
    sys_rd = 1'b0; sys_we = '0; sys_wdata = '0;
    acked = 1'b0;
    repeat (3) step();
    cmp_en = 1'b1;
    check("reset_uart_rd", 32'(uart_rd), 32'd0);
    check("reset_rdata", sys_rdata, 32'd0);
    check("reset_irq", 32'(irq), 32'd0);
    reset = 1'b0;
    step();

    // Single byte
    tx_q.push_back(8'h41);
    wait_idle(pulses);
    check("single_pulses", 32'(pulses), 32'd1);
    read_status(v);
    check("single_status", v, 32'h0000_0101);
    check("single_irq", 32'(irq), 32'd1);
    read_data(v);
    check("single_data", v, 32'h0000_0141);
    read_status(v);
    check("single_status_after", v, 32'h0000_0100);
    check("single_irq_after", 32'(irq), 32'd0);

    // Fill and overflow
    for (int i = 0; i <= 16; i++) tx_q.push_back(8'(i));
    drain();
    read_status(v);
    check("fill_status", v, 32'h0000_0130);
    for (int i = 0; i < 16; i++) begin
      read_data(v);
      check("fill_data", v, 32'h100 + 32'(i));
    end
    read_data(v);
    check("fill_empty_read", v, 32'd0);
    write_status(4'b0001, 32'h2);
    read_status(v);
    check("ovf_cleared", v, 32'h0000_0100);

    // Wrap-around
    foreach (exp_b[i]) exp_b.delete();
    for (int r = 0; r < 2; r++) begin
      exp_b.delete();
      for (int i = 0; i < (r == 0 ? 10 : 12); i++) begin
        exp_b.push_back(8'($urandom));
        tx_q.push_back(exp_b[i]);
      end
      drain();
      foreach (exp_b[i]) begin
        read_data(v);
        check("wrap_data", v, {23'd0, 1'b1, exp_b[i]});
      end
    end
    read_status(v);
    check("wrap_status", v, 32'h0000_0100);

    // Simultaneous push/pop while full
    for (int i = 0; i < 16; i++) tx_q.push_back(8'h20 + 8'(i));
    drain();
    tx_q.push_back(8'hAA);
    step();
    sys_select_data = 1'b1;
    sys_rd          = 1'b1;
    step();
    sys_select_data = 1'b0;
    sys_rd          = 1'b0;
    check("simul_head", sys_rdata, 32'h0000_0120);
    drain();
    read_status(v);
    check("simul_status", v, 32'h0000_0110);
    for (int i = 1; i < 16; i++) read_data(v);
    read_data(v);
    check("simul_last", v, 32'h0000_01AA);
    read_data(v);
    check("simul_empty", v, 32'd0);

    // Threshold and flush
    write_status(4'b0011, 32'h0000_0400);
    for (int i = 0; i < 3; i++) tx_q.push_back(8'h30 + 8'(i));
    drain();
    check("thr_irq_3", 32'(irq), 32'd0);
    tx_q.push_back(8'h33);
    drain();
    check("thr_irq_4", 32'(irq), 32'd1);
    write_status(4'b0011, 32'h0000_0401);
    check("flush_irq", 32'(irq), 32'd0);
    read_status(v);
    check("flush_status", v, 32'h0000_0400);
    write_status(4'b0010, 32'h0000_0100);

    // Reset mid-stream
    for (int i = 0; i < 5; i++) tx_q.push_back(8'h50 + 8'(i));
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      step();
      if (q.size() == 5 && uart_rd) found = 1'b1;
    end
    check("reset_setup", 32'(found), 32'd1);
    reset = 1'b1;
    tx_q.delete();
    step();
    check("midreset_uart_rd", 32'(uart_rd), 32'd0);
    check("midreset_irq", 32'(irq), 32'd0);
    reset = 1'b0;
    drain();
    read_status(v);
    check("midreset_status", v, 32'h0000_0100);

    // Randomized traffic: alternate push-heavy and read-heavy phases
    for (int blk = 0; blk < 12; blk++) begin
      rd_pct = (blk % 2) ? 55 : 5;
      for (int it = 0; it < 150; it++) begin
        if ($urandom_range(0, 2) == 0 && tx_q.size() < 3) tx_q.push_back(8'($urandom));
        if ($urandom_range(0, 99) < rd_pct) read_data(v);
        else case ($urandom_range(0, 19))
          0, 1: read_status(v);
          2: begin
            d = $urandom;
            d[15:8] = 8'($urandom_range(0, 18));
            d[0]    = ($urandom_range(0, 9) == 0);
            write_status(4'($urandom_range(0, 15)), d);
          end
          3: begin
            sys_select_data = 1'b1;
            sys_we          = 4'($urandom_range(1, 15));
            sys_wdata       = $urandom;
            step();
            sys_select_data = 1'b0;
            sys_we          = '0;
            sys_wdata       = '0;
          end
          default: step();
        endcase
      end
    end
    drain();
    repeat (2) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
